test_mailbox_monitor: RTL and testbench
=======================================

# test_mailbox_monitor

Synthesizable end-of-test monitor that snoops the core's data-memory write port alongside DataMemory in CoreTop. It detects pass/fail signature writes to a parametrised mailbox address, enforces a programmable cycle-timeout watchdog, and counts cycles and retired instructions. It also buffers byte writes to a console address in a small FIFO with a valid/ready drain, so benches and FPGA wrappers get one uniform status interface.

## Interface
- ADDR_W, 32, write-address width
- DATA_W, 32, write-data width; byte-enable width is DATA_W/8
- MAILBOX_ADDR, 32'h0000_0FFC, byte address of the mailbox word (word 1023)
- PASS_CODE, 32'hFFFF_1234, mailbox value meaning pass
- FAIL_CODE, 32'h1234_FFFF, mailbox value meaning fail
- CONSOLE_ADDR, 32'h0000_0FF8, byte address of the console byte port
- CNT_W, 32, width of the cycle, retire and timeout counters
- CON_DEPTH, 8, console FIFO depth (power of 2, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: clear counters and FIFO, enter RUN
- timeout_limit  in  CNT_W  watchdog limit in cycles; 0 disables
- wr_en  in  1  data-memory write strobe
- wr_addr  in  ADDR_W  write byte address
- wr_data  in  DATA_W  write data
- wr_be  in  DATA_W/8  byte enables
- retire  in  1  one pulse per retired instruction
- running  out  1  state == RUN
- done  out  1  state is PASS, FAIL or TIMEOUT
- pass / fail / timeout  out  1 each  one-hot terminal flags
- end_code  out  DATA_W  mailbox word that ended the test; 0 otherwise
- cycle_cnt  out  CNT_W  cycles spent in RUN
- retire_cnt  out  CNT_W  retire pulses counted in RUN
- con_valid  out  1  console FIFO not empty
- con_data  out  8  console FIFO head byte
- con_ready  in  1  consumer accepts head byte
- con_overflow  out  1  sticky: a console byte was dropped

## Operation
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. Reset → IDLE.
- IDLE: start → RUN. All snooped writes and retire pulses are ignored.
- Any state: start → RUN. Start clears cycle_cnt, retire_cnt, end_code, con_overflow and flushes the FIFO. Start has priority over every other event in that cycle.
- Mailbox hit: wr_en & wr_addr==MAILBOX_ADDR & wr_be all ones. A partial-byte write is not a hit.
- RUN with hit and wr_data==PASS_CODE → PASS, end_code←wr_data.
- RUN with hit and wr_data==FAIL_CODE → FAIL, end_code←wr_data.
- RUN with hit and any other value: stay in RUN, value ignored.
- RUN with timeout_limit≠0 and cycle_cnt==timeout_limit−1 → TIMEOUT. A pass/fail hit in the same cycle wins.
- Terminal states are sticky until start or rst. Counters freeze there.
- cycle_cnt increments once per RUN cycle and saturates at all ones. retire_cnt increments per retire in RUN and saturates.
- Console push: state==RUN & wr_en & wr_addr==CONSOLE_ADDR & wr_be[0] pushes wr_data[7:0].
- Pop: con_valid & con_ready.
- Push while full with no pop: byte dropped, con_overflow←1. Push and pop in the same cycle while full: both happen, no overflow.
- Push while empty: byte appears as con_data on the next cycle; there is no bypass.
- The FIFO keeps draining in terminal states.

## Timing
- Reset values: state IDLE; every flag 0; end_code, cycle_cnt, retire_cnt 0; FIFO empty; con_valid 0; con_data 0; con_overflow 0.
- All outputs are registered or decoded from registered state. There is no combinational path from wr_* or retire to any output.
- start sampled at edge k: running=1 after k, cycle_cnt=0 after k.
- cycle_cnt equals the number of RUN cycles since k. TIMEOUT asserts exactly timeout_limit cycles after k, with cycle_cnt=timeout_limit.
- Mailbox hit sampled at edge m: pass or fail and end_code visible after m. cycle_cnt holds its value from edge m (no increment at m).
- rst mid-test: immediate asynchronous return to reset values. Bytes in the FIFO are lost.
- FIFO pointers are log2(CON_DEPTH)+1 bits and wrap naturally. Full/empty is decoded from the MSB comparison.

## Test plan
- start; 5 retire pulses; full-word write of 32'hFFFF_1234 to 0x0FFC → pass=1, done=1, end_code=32'hFFFF_1234, retire_cnt=5; later writes have no effect.
- start; write 32'h1234_FFFF to 0x0FFC with wr_be=4'b0011, then with 4'b1111 → first write ignored; fail=1 after the second.
- timeout_limit=10; start; no mailbox write → timeout=1 exactly 10 cycles after start, cycle_cnt=10. Repeat with the pass write landing on cycle 10 → pass wins.
- con_ready=0; push 9 bytes 0x41..0x49 with CON_DEPTH=8 → con_overflow=1. Raise con_ready → drains 0x41..0x48 in order, then con_valid=0.
- FIFO full; push 0x5A with con_ready=1 in the same cycle → no overflow; 0x5A arrives last.
- In PASS state, pulse start → all counters 0, FIFO empty, running=1. Assert rst mid-RUN → IDLE and all outputs at reset values immediately.

Source files
------------

// File: rtl/test_mailbox_monitor.sv
// End-of-test monitor: snoops data-memory writes for a pass/fail mailbox word,
// runs a cycle watchdog, counts cycles/retires and buffers console bytes.
//
//   state     | meaning
//   S_IDLE    | waiting for start, snoop ignored
//   S_RUN     | test executing, counters and console active
//   S_PASS    | pass signature seen
//   S_FAIL    | fail signature seen
//   S_TIMEOUT | watchdog expired
module test_mailbox_monitor #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [ADDR_W-1:0] MAILBOX_ADDR = 32'h0000_0FFC,
  parameter logic [DATA_W-1:0] PASS_CODE = 32'hFFFF_1234,
  parameter logic [DATA_W-1:0] FAIL_CODE = 32'h1234_FFFF,
  parameter logic [ADDR_W-1:0] CONSOLE_ADDR = 32'h0000_0FF8,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned CON_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      timeout_limit,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  retire,
  output logic                  running,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [DATA_W-1:0]     end_code,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      retire_cnt,
  output logic                  con_valid,
  output logic [7:0]            con_data,
  input  logic                  con_ready,
  output logic                  con_overflow
);

  localparam int unsigned PTR_W = $clog2(CON_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  state_t state, state_nx;

  logic             mbox_hit;
  logic             pass_hit;
  logic             fail_hit;
  logic             tmo_hit;
  logic [CNT_W-1:0] tmo_last;

  assign mbox_hit = wr_en && (wr_addr == MAILBOX_ADDR) && (&wr_be);
  assign pass_hit = mbox_hit && (wr_data == PASS_CODE);
  assign fail_hit = mbox_hit && (wr_data == FAIL_CODE);
  assign tmo_last = timeout_limit - CNT_W'(1);
  assign tmo_hit  = (timeout_limit != '0) && (cycle_cnt == tmo_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Signature hits take precedence over a watchdog expiry in the same cycle.
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (pass_hit)      state_nx = S_PASS;
          else if (fail_hit) state_nx = S_FAIL;
          else if (tmo_hit)  state_nx = S_TIMEOUT;
        end
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    running = (state == S_RUN);
    pass    = (state == S_PASS);
    fail    = (state == S_FAIL);
    timeout = (state == S_TIMEOUT);
    done    = pass || fail || timeout;
  end

  // The signature-hit cycle does not count as a run cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      end_code   <= '0;
    end else if (start) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      end_code   <= '0;
    end else if (state == S_RUN) begin
      if (pass_hit || fail_hit) end_code <= wr_data;
      else if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire && (retire_cnt != '1)) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  logic [7:0]     con_mem [CON_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic           fifo_empty, fifo_full;
  logic           push_req, do_push, do_pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push_req   = (state == S_RUN) && wr_en && (wr_addr == CONSOLE_ADDR) && wr_be[0];
  assign do_pop     = !fifo_empty && con_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push    = push_req && (!fifo_full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      con_overflow <= 1'b0;
      for (int i = 0; i < int'(CON_DEPTH); i++) con_mem[i] <= '0;
    end else if (start) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      con_overflow <= 1'b0;
    end else begin
      if (do_push) begin
        con_mem[wr_ptr[PTR_W-1:0]] <= wr_data[7:0];
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (push_req && fifo_full && !do_pop) con_overflow <= 1'b1;
    end
  end

  assign con_valid = !fifo_empty;
  assign con_data  = con_mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_test_mailbox_monitor.sv
// Randomized plus directed bench for test_mailbox_monitor, checked every cycle
// against a queue-based behavioural model of the monitor.
module tb_test_mailbox_monitor;

  localparam logic [31:0] MBOX = 32'h0000_0FFC;
  localparam logic [31:0] CONS = 32'h0000_0FF8;
  localparam logic [31:0] PASS_C = 32'hFFFF_1234;
  localparam logic [31:0] FAIL_C = 32'h1234_FFFF;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] timeout_limit;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        retire;
  logic        running, done, pass, fail, timeout;
  logic [31:0] end_code, cycle_cnt, retire_cnt;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        con_overflow;

  test_mailbox_monitor dut (
    .clk(clk), .rst(rst), .start(start), .timeout_limit(timeout_limit),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .retire(retire), .running(running), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .end_code(end_code), .cycle_cnt(cycle_cnt),
    .retire_cnt(retire_cnt), .con_valid(con_valid), .con_data(con_data),
    .con_ready(con_ready), .con_overflow(con_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  bit check_en = 0;

  // Model: m_res 0=no result, 1=pass, 2=fail, 3=timeout.
  bit          m_run;
  int          m_res;
  logic [31:0] m_end, m_cyc, m_ret;
  logic [7:0]  mq[$];
  bit          m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic mreset();
    m_run = 0; m_res = 0; m_end = '0; m_cyc = '0; m_ret = '0; m_ovf = 0;
    mq.delete();
  endtask

  task automatic step();
    bit pop_ok, hit, push;
    int sz;
    if (rst) begin mreset(); return; end
    if (start) begin
      mreset();
      m_run = 1;
      return;
    end
    sz = mq.size();
    pop_ok = (sz != 0) && con_ready;
    if (pop_ok) void'(mq.pop_front());
    if (m_run) begin
      hit  = wr_en && (wr_addr == MBOX) && (wr_be == 4'hF);
      push = wr_en && (wr_addr == CONS) && wr_be[0];
      if (retire && m_ret != 32'hFFFF_FFFF) m_ret++;
      if (hit && wr_data == PASS_C) begin
        m_run = 0; m_res = 1; m_end = wr_data;
      end else if (hit && wr_data == FAIL_C) begin
        m_run = 0; m_res = 2; m_end = wr_data;
      end else begin
        if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
        if (timeout_limit != 0 && m_cyc == timeout_limit) begin
          m_run = 0; m_res = 3;
        end
      end
      if (push) begin
        if (sz < DEPTH || pop_ok) mq.push_back(wr_data[7:0]);
        else m_ovf = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("running", 32'(running), 32'(m_run));
      chk("done", 32'(done), 32'(m_res != 0));
      chk("pass", 32'(pass), 32'(m_res == 1));
      chk("fail", 32'(fail), 32'(m_res == 2));
      chk("timeout", 32'(timeout), 32'(m_res == 3));
      chk("end_code", end_code, m_end);
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("retire_cnt", retire_cnt, m_ret);
      chk("con_valid", 32'(con_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("con_data", 32'(con_data), 32'(mq[0]));
      chk("con_overflow", 32'(con_overflow), 32'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    start = 0; wr_en = 0; wr_addr = '0; wr_data = '0; wr_be = '0; retire = 0;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 0; wr_be = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_running"}, 32'(running), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_end_code"}, end_code, 0);
    chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
    chk({tag, "_retire_cnt"}, retire_cnt, 0);
    chk({tag, "_con_valid"}, 32'(con_valid), 0);
    chk({tag, "_con_data"}, 32'(con_data), 0);
    chk({tag, "_con_overflow"}, 32'(con_overflow), 0);
  endtask

  initial begin
    rst = 1; con_ready = 0; timeout_limit = '0;
    idle_in();
    mreset();
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 0;
    check_en = 1;
    tick();

    // Pass with five retires; later writes are ignored.
    pulse_start();
    chk("start_running", 32'(running), 1);
    retire = 1; repeat (5) tick(); retire = 0;
    wr(MBOX, PASS_C, 4'hF);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_done", 32'(done), 1);
    chk("t1_end_code", end_code, 32'hFFFF_1234);
    chk("t1_retire", retire_cnt, 5);
    wr(MBOX, FAIL_C, 4'hF);
    retire = 1; wr(CONS, 32'h41, 4'h1); retire = 0;
    chk("t1_sticky_pass", 32'(pass), 1);
    chk("t1_sticky_code", end_code, 32'hFFFF_1234);
    chk("t1_sticky_retire", retire_cnt, 5);
    chk("t1_no_console", 32'(con_valid), 0);

    // Partial write is not a hit.
    pulse_start();
    wr(MBOX, FAIL_C, 4'b0011);
    chk("t2_partial_fail", 32'(fail), 0);
    chk("t2_partial_run", 32'(running), 1);
    wr(MBOX, FAIL_C, 4'hF);
    chk("t2_fail", 32'(fail), 1);
    chk("t2_end_code", end_code, 32'h1234_FFFF);

    // Watchdog expiry exactly timeout_limit cycles after start.
    timeout_limit = 10;
    pulse_start();
    repeat (9) tick();
    chk("t3_not_yet", 32'(timeout), 0);
    chk("t3_cnt9", cycle_cnt, 9);
    tick();
    chk("t3_timeout", 32'(timeout), 1);
    chk("t3_cnt10", cycle_cnt, 10);

    // Pass write on the expiry cycle wins.
    pulse_start();
    repeat (9) tick();
    wr(MBOX, PASS_C, 4'hF);
    chk("t3b_pass", 32'(pass), 1);
    chk("t3b_no_timeout", 32'(timeout), 0);
    chk("t3b_cnt_hold", cycle_cnt, 9);
    timeout_limit = 0;

    // Restart from PASS.
    pulse_start();
    chk("t6_running", 32'(running), 1);
    chk("t6_cycle", cycle_cnt, 0);
    chk("t6_retire", retire_cnt, 0);
    chk("t6_end_code", end_code, 0);
    chk("t6_fifo_empty", 32'(con_valid), 0);

    // Overflow on ninth byte, then drain in order.
    con_ready = 0;
    for (int i = 0; i < 9; i++) wr(CONS, 32'h41 + 32'(i), 4'h1);
    chk("t4_overflow", 32'(con_overflow), 1);
    con_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_drain", 32'(con_data), 32'h41 + 32'(i));
      tick();
    end
    chk("t4_empty", 32'(con_valid), 0);

    // Push and pop together while full: no overflow, new byte last.
    pulse_start();
    con_ready = 0;
    for (int i = 0; i < 8; i++) wr(CONS, 32'h51 + 32'(i), 4'h1);
    con_ready = 1;
    wr(CONS, 32'h5A, 4'h1);
    chk("t5_no_overflow", 32'(con_overflow), 0);
    for (int i = 0; i < 7; i++) begin
      chk("t5_drain", 32'(con_data), 32'h52 + 32'(i));
      tick();
    end
    chk("t5_last", 32'(con_data), 32'h5A);
    tick();
    chk("t5_empty", 32'(con_valid), 0);

    // Asynchronous reset mid-run.
    pulse_start();
    con_ready = 0;
    retire = 1;
    for (int i = 0; i < 10; i++) wr(CONS, 32'h60 + 32'(i), 4'h1);
    retire = 0;
    #2 rst = 1;
    #1 chk_reset_vals("async_rst");
    mreset();
    tick();
    rst = 0;
    tick();

    // Randomized phase.
    pulse_start();
    for (int n = 0; n < 4000; n++) begin
      int r;
      start  = ($urandom_range(0, 149) == 0);
      if (start) timeout_limit = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 60));
      retire = $urandom_range(0, 1);
      con_ready = ($urandom_range(0, 2) != 0);
      wr_en  = $urandom_range(0, 1);
      r = $urandom_range(0, 3);
      wr_addr = (r == 0) ? MBOX : (r == 1) ? CONS : (r == 2) ? 32'h0000_0FF4 : $urandom;
      wr_be  = $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(0, 15));
      r = $urandom_range(0, 99);
      wr_data = (r < 3) ? PASS_C : (r < 6) ? FAIL_C : $urandom;
      if ($urandom_range(0, 29) == 0) begin
        #2 rst = 1;
        #1 chk_reset_vals("rand_rst");
        mreset();
        tick();
        rst = 0;
      end else begin
        tick();
      end
    end
    idle_in();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
